intr_ctrl_vec: RTL and testbench
================================

Name: intr_ctrl_vec

Overview:
- Parametrised successor to the single-line interrupt unit: Z80-style IFF1/IFF2, IM0/1/2 and edge-triggered NMI, extended to N_IRQ maskable request channels.
- Channels have per-channel edge/level mode, a mask register, fixed priority and a vectored ID/vector output.
- Sits beside the control sequencer; samples acceptance on setM1 and is released by the sequencer's ack/RETN controls.

Parameters:
- N_IRQ, 8, number of maskable request channels (1..16); ID_W = max(1, clog2(N_IRQ)) is derived.
- EDGE_MASK, all zeros, bit i = 1: channel i rising-edge latched; 0: level-sensitive.
- VEC_BASE, 8'h00, vector of channel 0.
- VEC_STRIDE, 2, vector increment per channel.

Ports:
- clk  in  1  clock; all state on the rising edge.
- reset  in  1  asynchronous, active-high reset.
- nmi  in  1  non-maskable request, rising-edge sensitive, synchronous to clk.
- irq  in  N_IRQ  maskable requests.
- irq_mask_we  in  1  write irq_mask from irq_mask_d.
- irq_mask_d  in  N_IRQ  mask data; 1 = channel masked.
- ctl_iffx_we  in  1  EI/DI strobe.
- ctl_iffx_bit  in  1  1 = EI, 0 = DI.
- ctl_iff1_iff2  in  1  RETN: copy IFF2 to IFF1, end NMI service.
- ctl_im_we  in  1  write interrupt mode from db.
- db  in  2  mode code.
- ctl_no_ints  in  1  suppress acceptance this cycle.
- setM1  in  1  instruction-boundary acceptance strobe.
- int_ack  in  1  sequencer finished INT acknowledge.
- iff1, iff2  out  1  interrupt enable flip-flops.
- im1, im2  out  1  mode decode.
- in_nmi  out  1  NMI being serviced.
- in_intr  out  1  INT being serviced.
- irq_id  out  ID_W  accepted channel index.
- vector  out  8  accepted vector.
- irq_pending  out  N_IRQ  unmasked pending requests.

Behaviour:
- Reset: all outputs and all internal state 0, including mode (IM0), mask, edge latches, nmi_prev, nmi_pend and ei_pend; vector resets to 0.
- Mode: on ctl_im_we, db 2'b0x -> IM0, 2'b10 -> IM1, 2'b11 -> IM2. im1/im2 are registered decodes, valid one edge after the write.
- DI (we=1, bit=0): iff1 = iff2 = 0 at the next edge; ei_pend cleared.
- EI (we=1, bit=1): iff2 = 1 and ei_pend = 1 at edge N+1; iff1 = 1 and ei_pend = 0 at edge N+2.
  - No maskable acceptance while ei_pend = 1.
  - A DI at N+1 cancels the EI.
- RETN: ctl_iff1_iff2 = 1 with ctl_iffx_we = 0 gives iff1 = iff2 and in_nmi = 0. If ctl_iffx_we = 1 in the same cycle, ctl_iffx_we dominates.
- NMI detect: a registered nmi_prev detects rising edges; an edge sets nmi_pend. A level held high produces only one request.
- NMI accept: setM1 & nmi_pend & !ctl_no_ints & !in_nmi gives at the next edge in_nmi = 1, iff1 = 0, iff2 unchanged, nmi_pend = 0.
  - A new NMI edge arriving while in_nmi = 1 stays pending and is accepted at the first setM1 after RETN.
- Pending vector: for channel i, pend[i] = EDGE_MASK[i] ? latch[i] : irq[i].
  - irq_pending = pend & ~mask, registered.
  - A mask write takes effect from the following cycle.
- INT accept: setM1 & iff1 & !ei_pend & !ctl_no_ints & !in_intr & |irq_pending, with no NMI accept in the same cycle. At the next edge:
  - in_intr = 1, iff1 = iff2 = 0;
  - irq_id = lowest-index set bit (channel 0 is highest priority);
  - vector = (VEC_BASE + irq_id*VEC_STRIDE) mod 256.
- Simultaneous NMI and INT eligibility: NMI wins; the INT request stays pending.
- Release: int_ack while in_intr gives in_intr = 0 and clears latch[irq_id] (edge channels only).
  - If the same channel shows a new edge in the ack cycle, the set wins.
  - irq_id and vector hold until the next accept.
  - int_ack while in_intr = 0 has no effect.
- Level channels are never latched: a request removed before acceptance is lost.
- reset asserted mid-service clears in_nmi, in_intr and all latches immediately (asynchronous).

Test Plan:
- Mode writes: db = 2'b10, then 2'b11, then 2'b00 with ctl_im_we = 1 -> im1/im2 = 1/0, 0/1, 0/0, each one edge after its write.
- EI then NMI:
  - EI -> iff2 = 1 at N+1, iff1 = 1 at N+2.
  - nmi 0->1, then setM1 -> in_nmi = 1, iff1 = 0, iff2 = 1.
  - nmi held high through a second setM1 -> no second request.
  - RETN -> iff1 = 1, in_nmi = 0.
- Priority and vector: N_IRQ = 8, VEC_BASE = 8'h40, stride 2, irq = 8'b0010_1000, iff1 = 1, setM1 -> irq_id = 3, vector = 8'h46, iff1 = iff2 = 0.
- Masking and EI delay:
  - mask = 8'h08 with the same irq -> irq_id = 5, vector = 8'h4A.
  - setM1 during ei_pend, or with ctl_no_ints = 1 -> no accept.
- Edge channel: EDGE_MASK[2] = 1, pulse irq[2] for 1 cycle while iff1 = 0.
  - Latch holds; later EI plus setM1 -> irq_id = 2.
  - int_ack -> latch cleared, in_intr = 0.
  - A new edge in the ack cycle -> pend remains 1.
- Simultaneous NMI edge and irq[0] at setM1 -> in_nmi = 1, in_intr = 0, irq_pending[0] = 1. Asserting reset mid-service -> all outputs 0.

Source files
------------

// File: rtl/intr_ctrl_vec_if.sv
// rtl/intr_ctrl_vec_if.sv - sequencer-side bundle for the vectored interrupt controller
interface intr_ctrl_vec_if #(
  parameter int N_IRQ = 8
);
  localparam int ID_W = (N_IRQ > 1) ? $clog2(N_IRQ) : 1;

  logic             nmi;
  logic [N_IRQ-1:0] irq;
  logic             irq_mask_we;
  logic [N_IRQ-1:0] irq_mask_d;
  logic             ctl_iffx_we;
  logic             ctl_iffx_bit;
  logic             ctl_iff1_iff2;
  logic             ctl_im_we;
  logic [1:0]       db;
  logic             ctl_no_ints;
  logic             setM1;
  logic             int_ack;

  logic             iff1;
  logic             iff2;
  logic             im1;
  logic             im2;
  logic             in_nmi;
  logic             in_intr;
  logic [ID_W-1:0]  irq_id;
  logic [7:0]       vector;
  logic [N_IRQ-1:0] irq_pending;

  modport master (
    output nmi, irq, irq_mask_we, irq_mask_d, ctl_iffx_we, ctl_iffx_bit,
           ctl_iff1_iff2, ctl_im_we, db, ctl_no_ints, setM1, int_ack,
    input  iff1, iff2, im1, im2, in_nmi, in_intr, irq_id, vector, irq_pending
  );

  modport slave (
    input  nmi, irq, irq_mask_we, irq_mask_d, ctl_iffx_we, ctl_iffx_bit,
           ctl_iff1_iff2, ctl_im_we, db, ctl_no_ints, setM1, int_ack,
    output iff1, iff2, im1, im2, in_nmi, in_intr, irq_id, vector, irq_pending
  );
endinterface

// File: rtl/intr_ctrl_vec.sv
// rtl/intr_ctrl_vec.sv - IFF1/IFF2, IM0-2, edge NMI and N-channel vectored maskable interrupts
module intr_ctrl_vec #(
  parameter int               N_IRQ      = 8,
  parameter logic [N_IRQ-1:0] EDGE_MASK  = '0,
  parameter logic [7:0]       VEC_BASE   = 8'h00,
  parameter int               VEC_STRIDE = 2
) (
  input logic           clk,
  input logic           reset,
  intr_ctrl_vec_if.slave bus
);
  localparam int ID_W = (N_IRQ > 1) ? $clog2(N_IRQ) : 1;

  logic             iff1_q, iff2_q, ei_pend_q;
  logic             im1_q, im2_q;
  logic             nmi_prev_q, nmi_pend_q, in_nmi_q, in_intr_q;
  logic [N_IRQ-1:0] mask_q, latch_q, irq_prev_q, pending_q;
  logic [ID_W-1:0]  irq_id_q;
  logic [7:0]       vector_q;

  logic             nmi_edge, nmi_accept, int_accept, retn, ack;
  logic [N_IRQ-1:0] pend, latch_clr, latch_set;
  logic [ID_W-1:0]  id_sel;
  logic [31:0]      vec_sum;
  logic [7:0]       vec_sel;

  assign nmi_edge   = bus.nmi & ~nmi_prev_q;
  assign nmi_accept = bus.setM1 & nmi_pend_q & ~bus.ctl_no_ints & ~in_nmi_q;
  // NMI takes precedence, so a simultaneously eligible INT simply stays pending
  assign int_accept = bus.setM1 & iff1_q & ~ei_pend_q & ~bus.ctl_no_ints & ~in_intr_q
                      & (|pending_q) & ~nmi_accept;
  // An EI/DI strobe in the same cycle overrides RETN entirely
  assign retn       = bus.ctl_iff1_iff2 & ~bus.ctl_iffx_we;
  assign ack        = bus.int_ack & in_intr_q;

  // Fixed priority: lowest-index pending channel wins; vector wraps modulo 256
  always_comb begin
    id_sel = '0;
    for (int i = N_IRQ - 1; i >= 0; i--) begin
      if (pending_q[i]) id_sel = ID_W'(i);
    end
    vec_sum = 32'(VEC_BASE) + 32'(id_sel) * 32'(VEC_STRIDE);
    vec_sel = vec_sum[7:0];
  end

  // Per-channel edge detect, release clear and edge/level pending select
  always_comb begin
    latch_clr = '0;
    latch_set = '0;
    pend      = '0;
    for (int i = 0; i < N_IRQ; i++) begin
      latch_clr[i] = ack && (irq_id_q == ID_W'(i));
      latch_set[i] = bus.irq[i] & ~irq_prev_q[i];
      pend[i]      = EDGE_MASK[i] ? latch_q[i] : bus.irq[i];
    end
  end

  // Interrupt mode register, decoded to im1/im2
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      im1_q <= 1'b0;
      im2_q <= 1'b0;
    end else if (bus.ctl_im_we) begin
      im1_q <= (bus.db == 2'b10);
      im2_q <= (bus.db == 2'b11);
    end
  end

  // Enable flip-flops: later statements take priority (EI/DI strobe last)
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      iff1_q    <= 1'b0;
      iff2_q    <= 1'b0;
      ei_pend_q <= 1'b0;
    end else begin
      if (retn) iff1_q <= iff2_q;
      if (ei_pend_q) begin
        iff1_q    <= 1'b1;
        ei_pend_q <= 1'b0;
      end
      if (nmi_accept) iff1_q <= 1'b0;
      if (int_accept) begin
        iff1_q <= 1'b0;
        iff2_q <= 1'b0;
      end
      if (bus.ctl_iffx_we) begin
        if (bus.ctl_iffx_bit) begin
          iff2_q    <= 1'b1;
          ei_pend_q <= 1'b1;
        end else begin
          iff1_q    <= 1'b0;
          iff2_q    <= 1'b0;
          ei_pend_q <= 1'b0;
        end
      end
    end
  end

  // NMI edge detection, pending flag and service state
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      nmi_prev_q <= 1'b0;
      nmi_pend_q <= 1'b0;
      in_nmi_q   <= 1'b0;
    end else begin
      nmi_prev_q <= bus.nmi;
      if (nmi_accept) nmi_pend_q <= 1'b0;
      if (nmi_edge)   nmi_pend_q <= 1'b1;
      if (nmi_accept) in_nmi_q <= 1'b1;
      else if (retn)  in_nmi_q <= 1'b0;
    end
  end

  // INT service state; id and vector hold until the next accept
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      in_intr_q <= 1'b0;
      irq_id_q  <= '0;
      vector_q  <= 8'h00;
    end else if (int_accept) begin
      in_intr_q <= 1'b1;
      irq_id_q  <= id_sel;
      vector_q  <= vec_sel;
    end else if (ack) begin
      in_intr_q <= 1'b0;
    end
  end

  // Mask, edge latches (a new edge beats the release clear) and registered pending
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      mask_q     <= '0;
      latch_q    <= '0;
      irq_prev_q <= '0;
      pending_q  <= '0;
    end else begin
      if (bus.irq_mask_we) mask_q <= bus.irq_mask_d;
      irq_prev_q <= bus.irq;
      latch_q    <= ((latch_q & ~latch_clr) | latch_set) & EDGE_MASK;
      pending_q  <= pend & ~mask_q;
    end
  end

  assign bus.iff1        = iff1_q;
  assign bus.iff2        = iff2_q;
  assign bus.im1         = im1_q;
  assign bus.im2         = im2_q;
  assign bus.in_nmi      = in_nmi_q;
  assign bus.in_intr     = in_intr_q;
  assign bus.irq_id      = irq_id_q;
  assign bus.vector      = vector_q;
  assign bus.irq_pending = pending_q;
endmodule

// File: tb/tb_intr_ctrl_vec.sv
// tb/tb_intr_ctrl_vec.sv - scoreboard bench for intr_ctrl_vec
module tb_intr_ctrl_vec;
  localparam int N = 8;

  localparam logic [24:0] M_IFF  = 25'h1800000;
  localparam logic [24:0] M_IM   = 25'h0600000;
  localparam logic [24:0] M_NMI  = 25'h0100000;
  localparam logic [24:0] M_INTR = 25'h0080000;
  localparam logic [24:0] M_ID   = 25'h0070000;
  localparam logic [24:0] M_VEC  = 25'h000FF00;
  localparam logic [24:0] M_PEND = 25'h00000FF;
  localparam logic [24:0] M_ALL  = 25'h1FFFFFF;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  intr_ctrl_vec_if #(.N_IRQ(N)) bus ();

  intr_ctrl_vec #(
    .N_IRQ(N), .EDGE_MASK(8'b0000_0100), .VEC_BASE(8'h40), .VEC_STRIDE(2)
  ) dut (
    .clk(clk),
    .reset(reset),
    .bus(bus)
  );

  typedef struct { string name; logic [24:0] exp; logic [24:0] care; } snap_t;
  typedef struct { string name; logic [2:0] id; logic [7:0] vec; } acc_t;

  snap_t snap_q[$];
  acc_t  acc_q[$];
  int    n_pass  = 0;
  int    n_total = 0;
  logic  intr_seen = 1'b0;
  logic [24:0] obs;

  assign obs = {bus.iff1, bus.iff2, bus.im1, bus.im2, bus.in_nmi, bus.in_intr,
                bus.irq_id, bus.vector, bus.irq_pending};

  function automatic logic [24:0] pk(input logic f1, input logic f2, input logic m1,
                                     input logic m2, input logic nm, input logic it,
                                     input logic [2:0] id, input logic [7:0] v,
                                     input logic [7:0] p);
    return {f1, f2, m1, m2, nm, it, id, v, p};
  endfunction

  // Monitor: compares queued snapshots and every fresh INT acceptance
  always @(negedge clk) begin
    snap_t s;
    acc_t  a;
    if (snap_q.size() > 0) begin
      s = snap_q.pop_front();
      n_total++;
      if ((obs & s.care) === (s.exp & s.care)) n_pass++;
      else $display("FAIL %s: got %h want %h (care %h)", s.name, obs & s.care, s.exp & s.care, s.care);
    end
    if (bus.in_intr === 1'b1 && !intr_seen) begin
      n_total++;
      if (acc_q.size() == 0) begin
        $display("FAIL unexpected_accept: got id %0d vector %h want no accept", bus.irq_id, bus.vector);
      end else begin
        a = acc_q.pop_front();
        if (bus.irq_id === a.id && bus.vector === a.vec) n_pass++;
        else $display("FAIL %s: got id %0d vector %h want id %0d vector %h",
                      a.name, bus.irq_id, bus.vector, a.id, a.vec);
      end
    end
    intr_seen = (bus.in_intr === 1'b1);
  end

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic chk(input string name, input logic [24:0] care, input logic [24:0] exp);
    snap_t s;
    s.name = name;
    s.exp  = exp;
    s.care = care;
    snap_q.push_back(s);
    @(negedge clk);
    #1;
    if (snap_q.size() != 0) begin
      $display("FAIL %s: got no sample want one", name);
      n_total++;
      snap_q.delete();
    end
  endtask

  task automatic expect_accept(input string name, input logic [2:0] id, input logic [7:0] vec);
    acc_t a;
    a.name = name;
    a.id   = id;
    a.vec  = vec;
    acc_q.push_back(a);
  endtask

  task automatic ei();
    bus.ctl_iffx_we  = 1'b1;
    bus.ctl_iffx_bit = 1'b1;
    step(1);
    bus.ctl_iffx_we  = 1'b0;
    bus.ctl_iffx_bit = 1'b0;
  endtask

  task automatic set_m1();
    bus.setM1 = 1'b1;
    step(1);
    bus.setM1 = 1'b0;
  endtask

  initial begin
    reset = 1'b1;
    bus.nmi = 0; bus.irq = '0; bus.irq_mask_we = 0; bus.irq_mask_d = '0;
    bus.ctl_iffx_we = 0; bus.ctl_iffx_bit = 0; bus.ctl_iff1_iff2 = 0;
    bus.ctl_im_we = 0; bus.db = 2'b00; bus.ctl_no_ints = 0; bus.setM1 = 0; bus.int_ack = 0;
    step(2);
    chk("reset_state", M_ALL, '0);
    reset = 1'b0;
    step(1);

    bus.ctl_im_we = 1; bus.db = 2'b10; step(1); bus.ctl_im_we = 0;
    chk("mode_im1", M_IM, pk(0, 0, 1, 0, 0, 0, 0, 0, 0));
    bus.ctl_im_we = 1; bus.db = 2'b11; step(1); bus.ctl_im_we = 0;
    chk("mode_im2", M_IM, pk(0, 0, 0, 1, 0, 0, 0, 0, 0));
    bus.ctl_im_we = 1; bus.db = 2'b00; step(1); bus.ctl_im_we = 0;
    chk("mode_im0", M_IM, pk(0, 0, 0, 0, 0, 0, 0, 0, 0));

    ei();
    chk("ei_edge1", M_IFF, pk(0, 1, 0, 0, 0, 0, 0, 0, 0));
    step(1);
    chk("ei_edge2", M_IFF, pk(1, 1, 0, 0, 0, 0, 0, 0, 0));
    bus.nmi = 1; step(1);
    set_m1();
    chk("nmi_accept", M_IFF | M_NMI | M_INTR, pk(0, 1, 0, 0, 1, 0, 0, 0, 0));
    bus.ctl_iff1_iff2 = 1; step(1); bus.ctl_iff1_iff2 = 0;
    chk("retn", M_IFF | M_NMI, pk(1, 1, 0, 0, 0, 0, 0, 0, 0));
    set_m1();
    chk("nmi_level_once", M_IFF | M_NMI, pk(1, 1, 0, 0, 0, 0, 0, 0, 0));
    bus.nmi = 0;

    bus.irq = 8'h28; step(1);
    chk("pend_level", M_PEND, pk(0, 0, 0, 0, 0, 0, 0, 0, 8'h28));
    expect_accept("prio_accept", 3'd3, 8'h46);
    set_m1();
    chk("int_accept_state", M_IFF | M_NMI | M_INTR, pk(0, 0, 0, 0, 0, 1, 0, 0, 0));
    bus.int_ack = 1; step(1); bus.int_ack = 0;
    chk("ack_hold", M_INTR | M_ID | M_VEC, pk(0, 0, 0, 0, 0, 0, 3'd3, 8'h46, 0));

    bus.irq_mask_we = 1; bus.irq_mask_d = 8'h08; step(1); bus.irq_mask_we = 0;
    step(1);
    chk("mask_pend", M_PEND, pk(0, 0, 0, 0, 0, 0, 0, 0, 8'h20));
    ei(); step(1);
    ei();
    chk("ei_again", M_IFF, pk(1, 1, 0, 0, 0, 0, 0, 0, 0));
    set_m1();
    chk("no_accept_ei_pend", M_INTR, '0);
    bus.ctl_no_ints = 1; set_m1(); bus.ctl_no_ints = 0;
    chk("no_accept_no_ints", M_IFF | M_INTR, pk(1, 1, 0, 0, 0, 0, 0, 0, 0));
    expect_accept("mask_accept", 3'd5, 8'h4A);
    set_m1();
    chk("mask_accept_state", M_IFF | M_INTR, pk(0, 0, 0, 0, 0, 1, 0, 0, 0));
    bus.int_ack = 1; step(1); bus.int_ack = 0;

    bus.irq_mask_we = 1; bus.irq_mask_d = 8'h00; bus.irq = 8'h00; step(1); bus.irq_mask_we = 0;
    step(1);
    bus.irq = 8'h04; step(1); bus.irq = 8'h00;
    step(1);
    chk("edge_latched", M_PEND, pk(0, 0, 0, 0, 0, 0, 0, 0, 8'h04));
    step(2);
    chk("edge_hold", M_PEND, pk(0, 0, 0, 0, 0, 0, 0, 0, 8'h04));
    ei(); step(1);
    expect_accept("edge_accept", 3'd2, 8'h44);
    set_m1();
    chk("edge_in_intr", M_INTR, pk(0, 0, 0, 0, 0, 1, 0, 0, 0));
    bus.int_ack = 1; step(1); bus.int_ack = 0;
    step(1);
    chk("edge_cleared", M_PEND | M_INTR, '0);

    bus.irq = 8'h04; step(1); bus.irq = 8'h00;
    step(1);
    ei(); step(1);
    expect_accept("edge_accept2", 3'd2, 8'h44);
    set_m1();
    bus.int_ack = 1; bus.irq = 8'h04; step(1); bus.int_ack = 0; bus.irq = 8'h00;
    step(1);
    chk("ack_edge_set_wins", M_PEND | M_INTR, pk(0, 0, 0, 0, 0, 0, 0, 0, 8'h04));

    ei(); step(1);
    bus.nmi = 1; bus.irq = 8'h01; step(1);
    set_m1();
    chk("nmi_wins", M_IFF | M_NMI | M_INTR | M_PEND, pk(0, 1, 0, 0, 1, 0, 0, 0, 8'h05));
    @(posedge clk);
    #2;
    reset = 1'b1;
    chk("async_reset", M_ALL, '0);
    reset = 1'b0;
    bus.nmi = 0; bus.irq = '0;
    step(1);

    n_total++;
    if (acc_q.size() == 0) n_pass++;
    else $display("FAIL accept_queue: got %0d outstanding want 0", acc_q.size());

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
